// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: device-side IEEE 1149.1-style TAP controller.
// Holds an 8-bit instruction register {rd_en, wr_en, x, x, chain_sel[3:0]},
// decodes it into one-hot scan-chain selects and DR strobes, and muxes the
// selected chain (or the 1-bit bypass register) back out on the inverted tdob.
`timescale 1ns/1ps

module jtag_tap_ctrl #(
  parameter int         NUM_CHAINS = 15,
  parameter logic [7:0] IR_CAPTURE = 8'b0000_0001
) (
  input  logic                  tck,
  input  logic                  trstb,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdob,
  input  logic [NUM_CHAINS-1:0] chain_tdo,
  output logic                  chain_tdi,
  output logic [NUM_CHAINS-1:0] chain_sel,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic                  capture_dr,
  output logic                  shift_dr,
  output logic                  update_dr,
  output logic [3:0]            tap_state
);

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  tap_state_e state, state_nxt;
  logic [7:0] ir_sr;
  logic [7:0] ir;
  logic       bypass;
  logic       chain_hit;
  logic       ir_unused;

  // TAP state register; trstb forces Test-Logic-Reset without waiting for tck.
  always_ff @(posedge tck or negedge trstb) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and process ordering cannot matter.
    if (!trstb) state <= TLR;
    else        state <= state_nxt;
  end

  // Standard 1149.1 next-state decode driven by tms.
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives
    // state_nxt, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      TLR:      state_nxt = tms ? TLR      : RTI;
      RTI:      state_nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_nxt = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_nxt = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_nxt = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_nxt = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_nxt = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_nxt = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // IR shift register: capture a fixed pattern, then shift LSB-first toward tdob.
  always_ff @(posedge tck or negedge trstb) begin
    if (!trstb)               ir_sr <= 8'h00;
    else if (state == CAP_IR) ir_sr <= IR_CAPTURE;
    else if (state == SH_IR)  ir_sr <= {tdi, ir_sr[7:1]};
  end

  // Instruction register: parallel load on Update-IR, cleared while in TLR.
  always_ff @(posedge tck or negedge trstb) begin
    if (!trstb)               ir <= 8'h00;
    else if (state == TLR)    ir <= 8'h00;
    else if (state == UPD_IR) ir <= ir_sr;
  end

  // Bypass register: captures 0, then delays tdi by one tck while shifting.
  always_ff @(posedge tck or negedge trstb) begin
    if (!trstb)               bypass <= 1'b0;
    else if (state == CAP_DR) bypass <= 1'b0;
    else if (state == SH_DR)  bypass <= tdi;
  end

  // One-hot chain select; a select of 0 or above NUM_CHAINS matches no bit,
  // which leaves the bypass register in the data path.
  always_comb begin
    chain_sel = '0;
    for (int k = 0; k < NUM_CHAINS; k++) begin
      chain_sel[k] = (ir[3:0] == 4'(k + 1));
    end
  end

  assign chain_hit = |chain_sel;

  // Serial output mux, inverted on the way to the tester; idle level is 1.
  always_comb begin
    tdob = 1'b1;
    case (state)
      SH_IR:   tdob = ~ir_sr[0];
      SH_DR:   tdob = chain_hit ? ~(|(chain_tdo & chain_sel)) : ~bypass;
      default: tdob = 1'b1;
    endcase
  end

  assign chain_tdi  = tdi;
  assign rd_en      = ir[7];
  assign wr_en      = ir[6];
  assign capture_dr = (state == CAP_DR) && chain_hit;
  assign shift_dr   = (state == SH_DR)  && chain_hit;
  assign update_dr  = (state == UPD_DR) && chain_hit;
  assign tap_state  = state;

  // IR[5:4] are stored for software visibility but carry no function here.
  assign ir_unused  = ^ir[5:4];

endmodule
